// File: rtl/sat_pkg.sv
// Shared SAT-engine constants and the BCP sequencer state encoding.
package sat_pkg;
    localparam int VAR_BITS     = 8;
    localparam int CT_BITS      = 13;
    localparam int CLAUSE_BITS  = 13;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE,
        VSE_RD,
        VSE_LAT,
        ISSUE,
        DRAIN,
        DONE
    } bcp_seq_state_t;
endpackage

// File: rtl/bcp_issue_pipe.sv
// Two-stage valid/cdb_addr shift that tracks clause-table reads through to eval_en.
module bcp_issue_pipe #(
    parameter int CLAUSE_BITS = 13
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issue,
    input  logic                   flush,
    input  logic [CLAUSE_BITS-1:0] ct_q,
    output logic [CLAUSE_BITS-1:0] cdb_addr,
    output logic                   eval_en,
    output logic                   empty
);
    logic                   v0_q;
    logic                   v1_q;
    logic [CLAUSE_BITS-1:0] cdb_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            v0_q <= issue;
            v1_q <= v0_q;
        end
    end

    // v0 marks the cycle ct_q carries the issued clause; capture it only then.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_q <= '0;
        end else if (v0_q) begin
            cdb_q <= ct_q;
        end
    end

    assign cdb_addr = cdb_q;
    assign eval_en  = v1_q;
    assign empty    = !v0_q && !v1_q;
endmodule

// File: rtl/bcp_sequencer.sv
// Sequences BCP for one assigned variable: range lookup, clause issue, drain, done.
module bcp_sequencer #(
    parameter int VAR_BITS     = sat_pkg::VAR_BITS,
    parameter int CT_BITS      = sat_pkg::CT_BITS,
    parameter int CLAUSE_BITS  = sat_pkg::CLAUSE_BITS,
    parameter int DRAIN_CYCLES = sat_pkg::DRAIN_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [VAR_BITS-1:0]    var_idx,
    input  logic                   stall,
    input  logic                   conflict,
    input  logic [2*CT_BITS-1:0]   vse_q,
    input  logic [CLAUSE_BITS-1:0] ct_q,
    output logic [VAR_BITS-1:0]    vse_addr,
    output logic [CT_BITS-1:0]     ct_addr,
    output logic [CLAUSE_BITS-1:0] cdb_addr,
    output logic                   eval_en,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [CT_BITS-1:0]     clause_cnt
);
    import sat_pkg::*;

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    bcp_seq_state_t      state_q, state_d;
    logic [VAR_BITS-1:0] vse_addr_q, vse_addr_d;
    logic [CT_BITS-1:0]  ptr_q, ptr_d;
    logic [CT_BITS-1:0]  end_q, end_d;
    logic [CT_BITS-1:0]  ct_addr_q, ct_addr_d;
    logic [CT_BITS-1:0]  cnt_q, cnt_d;
    logic [DC_W-1:0]     drain_q, drain_d;
    logic                aborted_q, aborted_d;
    logic                issue;
    logic                flush;
    logic                pipe_empty;

    always_comb begin
        state_d    = state_q;
        vse_addr_d = vse_addr_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        ct_addr_d  = ct_addr_q;
        cnt_d      = cnt_q;
        drain_d    = '0;
        aborted_d  = aborted_q;
        issue      = 1'b0;
        flush      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vse_addr_d = var_idx;
                    cnt_d      = '0;
                    aborted_d  = 1'b0;
                    state_d    = VSE_RD;
                end
            end
            VSE_RD: state_d = VSE_LAT;
            VSE_LAT: begin
                ptr_d   = vse_q[CT_BITS-1:0];
                end_d   = vse_q[2*CT_BITS-1:CT_BITS];
                state_d = (vse_q[CT_BITS-1:0] >= vse_q[2*CT_BITS-1:CT_BITS]) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (!stall) begin
                    issue     = 1'b1;
                    ct_addr_d = ptr_q;
                    ptr_d     = ptr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (ptr_q == end_q - 1'b1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q;
                if (pipe_empty) begin
                    if (int'(drain_q) >= DRAIN_CYCLES - 1) begin
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A conflict overrides everything, including a simultaneous last issue.
        if (conflict && state_q != IDLE && state_q != DONE) begin
            issue     = 1'b0;
            flush     = 1'b1;
            ptr_d     = ptr_q;
            ct_addr_d = ct_addr_q;
            cnt_d     = cnt_q;
            aborted_d = 1'b1;
            state_d   = DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            vse_addr_q <= '0;
            ptr_q      <= '0;
            end_q      <= '0;
            ct_addr_q  <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vse_addr_q <= vse_addr_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            ct_addr_q  <= ct_addr_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            aborted_q  <= aborted_d;
        end
    end

    bcp_issue_pipe #(
        .CLAUSE_BITS(CLAUSE_BITS)
    ) u_issue_pipe (
        .clock   (clock),
        .reset   (reset),
        .issue   (issue),
        .flush   (flush),
        .ct_q    (ct_q),
        .cdb_addr(cdb_addr),
        .eval_en (eval_en),
        .empty   (pipe_empty)
    );

    assign vse_addr   = vse_addr_q;
    assign ct_addr    = issue ? ptr_q : ct_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = done && aborted_q;
    assign clause_cnt = cnt_q;
endmodule

// File: tb/tb_bcp_sequencer.sv
// Randomized scoreboard bench for bcp_sequencer with behavioural RAMs and reference timing model.
module tb_bcp_sequencer;
    localparam int VB = 8;
    localparam int CB = 13;
    localparam int KB = 13;
    localparam int DC = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [VB-1:0]   var_idx;
    logic            stall;
    logic            conflict;
    logic [2*CB-1:0] vse_q;
    logic [KB-1:0]   ct_q;
    logic [VB-1:0]   vse_addr;
    logic [CB-1:0]   ct_addr;
    logic [KB-1:0]   cdb_addr;
    logic            eval_en;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [CB-1:0]   clause_cnt;

    logic [2*CB-1:0] vse_mem [0:255];
    logic [KB-1:0]   ct_mem  [0:8191];
    bit              stall_at [0:63];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int cyc; int ab; int cnt; } dn_t;
    ev_t exp_ev[$];
    dn_t exp_dn[$];

    bcp_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .var_idx   (var_idx),
        .stall     (stall),
        .conflict  (conflict),
        .vse_q     (vse_q),
        .ct_q      (ct_q),
        .vse_addr  (vse_addr),
        .ct_addr   (ct_addr),
        .cdb_addr  (cdb_addr),
        .eval_en   (eval_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .clause_cnt(clause_cnt)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAMs with one cycle of latency.
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        vse_q <= vse_mem[vse_addr];
        ct_q  <= ct_mem[ct_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents eval_en or done.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (eval_en) begin
                    check("eval_expected", exp_ev.size() > 0, 1);
                    if (exp_ev.size() > 0) begin
                        ev_t e;
                        e = exp_ev.pop_front();
                        check("eval_cycle", cyc, e.cyc);
                        check("eval_cdb_addr", cdb_addr, e.val);
                    end
                end
                if (done) begin
                    check("done_expected", exp_dn.size() > 0, 1);
                    if (exp_dn.size() > 0) begin
                        dn_t d;
                        d = exp_dn.pop_front();
                        check("done_cycle", cyc, d.cyc);
                        check("done_aborted", aborted, d.ab);
                        check("done_clause_cnt", clause_cnt, d.cnt);
                        check("done_busy", busy, 1);
                        check("evals_left_at_done", exp_ev.size(), 0);
                    end
                end
            end
        end
    end

    // One sweep. cr: -1 none, 0 random conflict, >0 conflict at that cycle offset.
    // restart_rel: offset of an extra start pulse that must be ignored (-1 none).
    task automatic run(input int vi, input int sp, input int ep, input int cr, input int restart_rel);
        int n;
        int rel;
        int s;
        int done_rel;
        int cnt;
        int ab;
        int c;
        int ir[$];
        logic [CB-1:0] ep_b;
        logic [CB-1:0] sp_b;
        ep_b = ep[CB-1:0];
        sp_b = sp[CB-1:0];
        vse_mem[vi] = {ep_b, sp_b};
        n = (ep > sp) ? ep - sp : 0;
        rel = 3;
        for (int i = 0; i < n; i++) begin
            while (stall_at[rel]) rel++;
            ir.push_back(rel);
            rel++;
        end
        done_rel = (n == 0) ? 3 : ir[n-1] + 2 + DC + 1;
        ab = 0;
        c = cr;
        if (c == 0) c = $urandom_range(done_rel - 1, 1);
        if (c > 0 && c < done_rel) begin
            ab = 1;
            done_rel = c + 1;
        end
        s = cyc;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (ab == 0 || ir[i] < c) cnt++;
            if (ab == 0 || ir[i] + 2 <= c) begin
                ev_t e;
                e.cyc = s + ir[i] + 2;
                e.val = int'(ct_mem[sp + i]);
                exp_ev.push_back(e);
            end
        end
        begin
            dn_t d;
            d.cyc = s + done_rel;
            d.ab  = ab;
            d.cnt = cnt;
            exp_dn.push_back(d);
        end
        for (int r = 0; r <= done_rel + 1; r++) begin
            start    = (r == 0) || (r == restart_rel);
            var_idx  = (r == 0) ? vi[VB-1:0] : ~vi[VB-1:0];
            stall    = stall_at[r];
            conflict = (ab == 1) && (r == c);
            @(posedge clock);
            #1;
            if (r == 0) begin
                check("busy_after_start", busy, 1);
                check("vse_addr", vse_addr, vi);
            end
            if (r == done_rel) check("busy_after_done", busy, 0);
        end
        start = 1'b0;
        stall = 1'b0;
        conflict = 1'b0;
        @(posedge clock);
        #1;
        check("done_count", exp_dn.size(), 0);
        exp_ev.delete();
        exp_dn.delete();
    endtask

    task automatic clear_stall();
        for (int r = 0; r < 64; r++) stall_at[r] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        conflict = 1'b0;
        var_idx = '0;
        for (int i = 0; i < 256; i++) vse_mem[i] = '0;
        for (int i = 0; i < 8192; i++) ct_mem[i] = '0;
        clear_stall();
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_eval_en", eval_en, 0);
        check("rst_vse_addr", vse_addr, 0);
        check("rst_ct_addr", ct_addr, 0);
        check("rst_cdb_addr", cdb_addr, 0);
        check("rst_clause_cnt", clause_cnt, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        ct_mem[8] = 13'd3;
        ct_mem[9] = 13'd7;
        ct_mem[10] = 13'd9;
        ct_mem[11] = 13'd20;
        run(5, 8, 12, -1, -1);
        run(2, 4, 4, -1, -1);
        stall_at[5] = 1'b1;
        stall_at[6] = 1'b1;
        run(5, 8, 12, -1, -1);
        clear_stall();
        run(5, 8, 12, 6, -1);

        // Reset while issuing clauses.
        vse_mem[5] = {13'd12, 13'd8};
        var_idx = 8'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_eval_en", eval_en, 0);
        check("midrst_clause_cnt", clause_cnt, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        run(5, 8, 12, -1, -1);

        run(5, 8, 12, -1, 2);
        for (int i = 0; i < 4; i++) ct_mem[8187 + i] = 13'(i * 1000 + 17);
        run(9, 8187, 8191, -1, -1);
        run(7, 100, 50, -1, -1);

        for (int k = 0; k < 40; k++) begin
            int vi;
            int sp;
            int len;
            int ep;
            int mode;
            vi   = $urandom_range(255, 0);
            len  = $urandom_range(6, 0);
            mode = $urandom_range(9, 0);
            sp   = (mode == 0) ? 8191 - len : $urandom_range(8000, 5);
            ep   = (mode == 1) ? sp - $urandom_range(5, 1) : sp + len;
            for (int i = 0; i < len; i++) ct_mem[sp + i] = 13'($urandom_range(8191, 0));
            for (int r = 0; r < 64; r++) stall_at[r] = (r < 32) && ($urandom_range(3, 0) == 0);
            run(vi, sp, ep, ($urandom_range(4, 0) == 0) ? 0 : -1, -1);
        end
        clear_stall();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
